// File: rtl/imm_pkg.sv
// Shared constants for the immediate-decode stage: RV opcodes, format codes
// and the skid-buffer state encoding.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate extraction and format classification.
// Optional CSR zimm decode is enabled by defining IMMGEN_CSR_ZIMM_EN.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  logic            en_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o,
  output logic            tgt_valid_o
);

  // Every format fits in 32 bits; widening the signed value sign-extends from bit 31.
  logic signed [31:0] imm32;

  always_comb begin
    imm32       = '0;
    fmt_o       = FMT_NONE;
    illegal_o   = 1'b0;
    tgt_valid_o = 1'b0;
    if (en_i) begin
      case (instr_i[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
          fmt_o = FMT_I;
        end
        OPC_STORE: begin
          imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
          fmt_o = FMT_S;
        end
        OPC_BRANCH: begin
          imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
          fmt_o       = FMT_B;
          tgt_valid_o = 1'b1;
        end
        OPC_LUI: begin
          imm32 = {instr_i[31:12], 12'b0};
          fmt_o = FMT_U;
        end
        OPC_AUIPC: begin
          imm32       = {instr_i[31:12], 12'b0};
          fmt_o       = FMT_U;
          tgt_valid_o = 1'b1;
        end
        OPC_JAL: begin
          imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};
          fmt_o       = FMT_J;
          tgt_valid_o = 1'b1;
        end
        OPC_SYSTEM: begin
`ifdef IMMGEN_CSR_ZIMM_EN
          // Only the immediate CSR forms (funct3 101/110/111) carry a zimm.
          if (instr_i[14] && (instr_i[13:12] != 2'b00)) begin
            imm32 = {27'b0, instr_i[19:15]};
            fmt_o = FMT_Z;
          end
`else
          illegal_o = 1'b1;
`endif
        end
        default: illegal_o = 1'b1;
      endcase
    end
  end

  assign imm_o = XLEN'(imm32);

`ifndef IMMGEN_CSR_ZIMM_EN
  logic unused_funct3;
  assign unused_funct3 = ^instr_i[14:12];
`endif

endmodule

// File: rtl/imm_decode_pipe.sv
// Registered immediate-decode stage with valid/ready handshake, PC-relative
// target precompute and optional two-entry skid buffer. Macro: IMMGEN_CSR_ZIMM_EN.
//
// Handshake: a beat transfers on a rising clk edge when valid && ready are both
// high; the sender holds valid and data stable until that edge; beats leave in
// acceptance order, never dropped or duplicated.
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target,
  output logic            out_tgt_valid,
  output logic [1:0]      dbg_state
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            tgt_valid;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic            dec_tgt_valid;
  entry_t          in_entry;
  entry_t          out_entry;
  logic            in_acc;
  logic            out_acc;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr_i     (in_instr),
    .en_i        (in_en),
    .imm_o       (dec_imm),
    .fmt_o       (dec_fmt),
    .illegal_o   (dec_illegal),
    .tgt_valid_o (dec_tgt_valid)
  );

  always_comb begin
    in_entry.imm       = dec_imm;
    in_entry.fmt       = dec_fmt;
    in_entry.illegal   = dec_illegal;
    in_entry.pc        = in_pc;
    in_entry.target    = dec_tgt_valid ? (in_pc + dec_imm) : '0;
    in_entry.tgt_valid = dec_tgt_valid;
  end

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e state_q, state_d;
      entry_t      out_q, out_d;
      entry_t      skid_q, skid_d;
      logic        in_ready_q;

      always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
          ST_EMPTY: begin
            if (in_acc) begin
              out_d   = in_entry;
              state_d = ST_ONE;
            end
          end
          ST_ONE: begin
            if (in_acc && out_acc) begin
              out_d = in_entry;
            end else if (in_acc) begin
              skid_d  = in_entry;
              state_d = ST_FULL;
            end else if (out_acc) begin
              state_d = ST_EMPTY;
            end
          end
          ST_FULL: begin
            // in_ready is low here, so only the drain side can move.
            if (out_acc) begin
              out_d   = skid_q;
              state_d = ST_ONE;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q    <= ST_EMPTY;
          out_q      <= '0;
          skid_q     <= '0;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          out_q      <= out_d;
          skid_q     <= skid_d;
          in_ready_q <= (state_d != ST_FULL);
        end
      end

      assign in_ready  = in_ready_q;
      assign out_valid = (state_q != ST_EMPTY);
      assign out_entry = out_q;
      assign dbg_state = state_q;
    end else begin : g_single
      logic   valid_q, valid_d;
      entry_t out_q, out_d;

      always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (in_acc) begin
          out_d   = in_entry;
          valid_d = 1'b1;
        end else if (out_acc) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          out_q   <= '0;
        end else begin
          valid_q <= valid_d;
          out_q   <= out_d;
        end
      end

      assign in_ready  = !valid_q || out_ready;
      assign out_valid = valid_q;
      assign out_entry = out_q;
      assign dbg_state = valid_q ? ST_ONE : ST_EMPTY;
    end
  endgenerate

  assign out_imm       = out_entry.imm;
  assign out_fmt       = out_entry.fmt;
  assign out_illegal   = out_entry.illegal;
  assign out_pc        = out_entry.pc;
  assign out_target    = out_entry.target;
  assign out_tgt_valid = out_entry.tgt_valid;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: three instances (XLEN32/skid, XLEN64/skid, XLEN32/single),
// directed vector table, backpressure and reset-in-stall sequences, randomized scoreboard.
module tb_imm_decode_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- per-instance signals ----------------
  logic        in_valid_a [3];
  logic        out_ready_a[3];
  logic        in_en_a    [3];
  logic [31:0] in_instr_a [3];
  logic [63:0] in_pc_a    [3];
  logic        in_ready_a [3];
  logic        out_valid_a[3];
  logic        ill_a      [3];
  logic        tv_a       [3];
  logic [2:0]  fmt_a      [3];
  logic [1:0]  st_a       [3];
  logic [63:0] imm_a      [3];
  logic [63:0] pc_a       [3];
  logic [63:0] tgt_a      [3];
  logic [31:0] imm0, pc0, tgt0, imm2, pc2, tgt2;

  assign imm_a[0] = {32'h0, imm0};
  assign pc_a[0]  = {32'h0, pc0};
  assign tgt_a[0] = {32'h0, tgt0};
  assign imm_a[2] = {32'h0, imm2};
  assign pc_a[2]  = {32'h0, pc2};
  assign tgt_a[2] = {32'h0, tgt2};

  imm_decode_pipe #(.XLEN(32), .SKID(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_instr(in_instr_a[0]), .in_pc(in_pc_a[0][31:0]), .in_en(in_en_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_imm(imm0),
    .out_fmt(fmt_a[0]), .out_illegal(ill_a[0]), .out_pc(pc0), .out_target(tgt0),
    .out_tgt_valid(tv_a[0]), .dbg_state(st_a[0]));

  imm_decode_pipe #(.XLEN(64), .SKID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_instr(in_instr_a[1]), .in_pc(in_pc_a[1]), .in_en(in_en_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_imm(imm_a[1]),
    .out_fmt(fmt_a[1]), .out_illegal(ill_a[1]), .out_pc(pc_a[1]), .out_target(tgt_a[1]),
    .out_tgt_valid(tv_a[1]), .dbg_state(st_a[1]));

  imm_decode_pipe #(.XLEN(32), .SKID(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_instr(in_instr_a[2]), .in_pc(in_pc_a[2][31:0]), .in_en(in_en_a[2]),
    .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_imm(imm2),
    .out_fmt(fmt_a[2]), .out_illegal(ill_a[2]), .out_pc(pc2), .out_target(tgt2),
    .out_tgt_valid(tv_a[2]), .dbg_state(st_a[2]));

  // ---------------- scoreboard helpers ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic int dut_xlen(input int d);
    return (d == 1) ? 64 : 32;
  endfunction

  function automatic bit dut_skid(input int d);
    return (d != 2);
  endfunction

  function automatic logic [63:0] xmask(input int d);
    return (dut_xlen(d) == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected entry packing: {imm[64], fmt[3], illegal, tgt_valid, target[64], pc[64]}
  function automatic logic [196:0] pack_exp(input logic [63:0] imm, input logic [2:0] fmt,
                                            input logic ill, input logic tv,
                                            input logic [63:0] tgt, input logic [63:0] pc);
    return {imm, fmt, ill, tv, tgt, pc};
  endfunction

  // Reference decode: RV immediate rules written directly as arithmetic on fields.
  function automatic logic [196:0] model(input int xlen, input logic [31:0] ins,
                                         input logic en, input logic [63:0] pc);
    longint      imm = 0;
    logic [2:0]  fmt = 3'd0;
    logic        ill = 1'b0;
    logic        tv  = 1'b0;
    logic [63:0] m, imm_u, pc_u, tgt;
    m = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    if (en) begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67: begin imm = longint'($signed(ins[31:20])); fmt = 3'd1; end
        7'h23: begin imm = longint'($signed({ins[31:25], ins[11:7]})); fmt = 3'd2; end
        7'h63: begin
          imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
          fmt = 3'd3; tv = 1'b1;
        end
        7'h37: begin imm = longint'($signed({ins[31:12], 12'b0})); fmt = 3'd4; end
        7'h17: begin imm = longint'($signed({ins[31:12], 12'b0})); fmt = 3'd4; tv = 1'b1; end
        7'h6F: begin
          imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
          fmt = 3'd5; tv = 1'b1;
        end
        7'h73: begin
`ifdef IMMGEN_CSR_ZIMM_EN
          if (ins[14:12] >= 3'd5) begin imm = longint'(ins[19:15]); fmt = 3'd6; end
`else
          ill = 1'b1;
`endif
        end
        default: ill = 1'b1;
      endcase
    end
    imm_u = 64'(imm) & m;
    pc_u  = pc & m;
    tgt   = tv ? ((pc_u + imm_u) & m) : 64'h0;
    return pack_exp(imm_u, fmt, ill, tv, tgt, pc_u);
  endfunction

  task automatic check_entry(input int d, input string tag, input logic [196:0] e);
    check($sformatf("%s d%0d imm", tag, d), imm_a[d], e[196:133]);
    check($sformatf("%s d%0d fmt", tag, d), 64'(fmt_a[d]), 64'(e[132:130]));
    check($sformatf("%s d%0d illegal", tag, d), 64'(ill_a[d]), 64'(e[129]));
    check($sformatf("%s d%0d tgt_valid", tag, d), 64'(tv_a[d]), 64'(e[128]));
    check($sformatf("%s d%0d target", tag, d), tgt_a[d], e[127:64]);
    check($sformatf("%s d%0d pc", tag, d), pc_a[d], e[63:0]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic        en;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic        tv;
    logic [63:0] tgt;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic fill_vectors();
    vecs[0]  = '{32'hFFF00093, 1'b1, 64'h0,    64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 1'b0, 64'h0};
    vecs[1]  = '{32'hFE000EE3, 1'b1, 64'h100,  64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 1'b1, 64'hFC};
    vecs[2]  = '{32'h800000B7, 1'b1, 64'h0,    64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 1'b0, 64'h0};
    vecs[3]  = '{32'h0000007F, 1'b1, 64'h40,   64'h0,                   3'd0, 1'b1, 1'b0, 64'h0};
    vecs[4]  = '{32'h0000007F, 1'b0, 64'h40,   64'h0,                   3'd0, 1'b0, 1'b0, 64'h0};
`ifdef IMMGEN_CSR_ZIMM_EN
    vecs[5]  = '{32'h300FD073, 1'b1, 64'h80,   64'h1F,                  3'd6, 1'b0, 1'b0, 64'h0};
`else
    vecs[5]  = '{32'h300FD073, 1'b1, 64'h80,   64'h0,                   3'd0, 1'b1, 1'b0, 64'h0};
`endif
    vecs[6]  = '{32'h00001097, 1'b1, 64'h2000, 64'h1000,                3'd4, 1'b0, 1'b1, 64'h3000};
    vecs[7]  = '{32'h0080006F, 1'b1, 64'h10,   64'h8,                   3'd5, 1'b0, 1'b1, 64'h18};
    vecs[8]  = '{32'hFE000EE3, 1'b1, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[9]  = '{32'hFE000FA3, 1'b1, 64'h8,    64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 1'b0, 1'b0, 64'h0};
    vecs[10] = '{32'h7FF00003, 1'b1, 64'h0,    64'h7FF,                 3'd1, 1'b0, 1'b0, 64'h0};
    vecs[11] = '{32'h80000067, 1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0, 1'b0, 64'h0};
    vecs[12] = '{32'h800000B7, 1'b0, 64'h0,    64'h0,                   3'd0, 1'b0, 1'b0, 64'h0};
    vecs[13] = '{32'h00001097, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1000, 3'd4, 1'b0, 1'b1, 64'hFF0};
  endtask

  task automatic run_table();
    logic [63:0] m;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("vec%0d d%0d idle before accept", i, d), 64'(out_valid_a[d]), 64'd0);
        in_instr_a[d]  = vecs[i].instr;
        in_en_a[d]     = vecs[i].en;
        in_pc_a[d]     = vecs[i].pc;
        in_valid_a[d]  = 1'b1;
        out_ready_a[d] = 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        in_valid_a[d] = 1'b0;
        m = xmask(d);
        check($sformatf("vec%0d d%0d out_valid", i, d), 64'(out_valid_a[d]), 64'd1);
        check_entry(d, $sformatf("vec%0d", i),
                    pack_exp(vecs[i].imm & m, vecs[i].fmt, vecs[i].ill, vecs[i].tv,
                             vecs[i].tgt & m, vecs[i].pc & m));
      end
    end
  endtask

  // ---------------- backpressure sequence on the XLEN32 skid instance ----------------
  task automatic bp_test();
    logic [31:0] seq[3];
    logic [63:0] got[$];
    int          got_cyc[$];
    int          nacc = 0;
    int          acc2_cyc = -1;
    int          low_cyc = -1;
    seq[0] = 32'h00100093;
    seq[1] = 32'h00200093;
    seq[2] = 32'h00300093;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    in_en_a[0]     = 1'b1;
    in_pc_a[0]     = 64'h0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_instr_a[0] = seq[(nacc < 3) ? nacc : 2];
      in_valid_a[0] = (nacc < 3);
      #1;
      if (!in_ready_a[0] && low_cyc < 0) low_cyc = cyc;
      if (in_valid_a[0] && in_ready_a[0]) begin
        nacc++;
        if (nacc == 2) acc2_cyc = cyc;
      end
      @(negedge clk);
    end
    check("bp accepted while stalled", 64'(nacc), 64'd2);
    check("bp in_ready low when full", 64'(in_ready_a[0]), 64'd0);
    check("bp in_ready fall cycle", 64'(low_cyc), 64'(acc2_cyc + 1));
    check("bp head held", imm_a[0], 64'd1);
    out_ready_a[0] = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_instr_a[0] = seq[(nacc < 3) ? nacc : 2];
      in_valid_a[0] = (nacc < 3);
      #1;
      if (out_valid_a[0] && out_ready_a[0]) begin
        got.push_back(imm_a[0]);
        got_cyc.push_back(cyc);
      end
      if (in_valid_a[0] && in_ready_a[0]) nacc++;
      @(negedge clk);
    end
    in_valid_a[0] = 1'b0;
    check("bp drained count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp order %0d", i), (i < got.size()) ? got[i] : 64'hDEAD, 64'(i + 1));
      check($sformatf("bp consecutive %0d", i),
            64'((i < got_cyc.size()) ? (got_cyc[i] - got_cyc[0]) : -1), 64'(i));
    end
    check("bp all accepted", 64'(nacc), 64'd3);
    check("bp empty after drain", 64'(out_valid_a[0]), 64'd0);
  endtask

  // ---------------- reset while FULL ----------------
  task automatic reset_stall_test();
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    in_en_a[0]     = 1'b1;
    in_instr_a[0]  = 32'hFE000EE3;
    in_pc_a[0]     = 64'h100;
    in_valid_a[0]  = 1'b1;
    @(negedge clk);
    in_instr_a[0] = 32'h0080006F;
    in_pc_a[0]    = 64'h10;
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    check("rst precondition full", 64'(in_ready_a[0]), 64'd0);
    check("rst precondition tgt", tgt_a[0], 64'hFC);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 64'(out_valid_a[0]), 64'd0);
    check("rst in_ready", 64'(in_ready_a[0]), 64'd1);
    check_entry(0, "rst", pack_exp(64'h0, 3'd0, 1'b0, 1'b0, 64'h0, 64'h0));
    @(negedge clk);
    rst_n          = 1'b1;
    out_ready_a[0] = 1'b1;
    in_instr_a[0]  = 32'h00500093;
    in_pc_a[0]     = 64'h40;
    in_valid_a[0]  = 1'b1;
    #1;
    check("post-rst no stale output", 64'(out_valid_a[0]), 64'd0);
    @(negedge clk);
    in_valid_a[0] = 1'b0;
    check("post-rst latency valid", 64'(out_valid_a[0]), 64'd1);
    check_entry(0, "post-rst", pack_exp(64'd5, 3'd1, 1'b0, 1'b0, 64'h0, 64'h40));
    @(negedge clk);
    check("post-rst single output", 64'(out_valid_a[0]), 64'd0);
  endtask

  // ---------------- randomized scoreboard run ----------------
  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[6:0] = 7'h13;
      1: r[6:0] = 7'h03;
      2: r[6:0] = 7'h67;
      3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h37;
      6: r[6:0] = 7'h17;
      7: r[6:0] = 7'h6F;
      8: r[6:0] = 7'h73;
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_random(input int d, input int cycles);
    logic [196:0] exp_q[$];
    logic [196:0] e;
    bit           acc_prev = 1'b0;
    bit           draining;
    int           occ;
    int           rp = 100;
    in_valid_a[d] = 1'b0;
    for (int cyc = 0; cyc < cycles + 20; cyc++) begin
      @(negedge clk);
      draining = (cyc >= cycles);
      if (cyc % 50 == 0) rp = (cyc % 150 == 0) ? 100 : ((cyc % 150 == 50) ? 50 : 10);
      if (acc_prev) in_valid_a[d] = 1'b0;
      if (!in_valid_a[d] && !draining && $urandom_range(0, 3) != 0) begin
        in_instr_a[d] = rand_instr();
        in_en_a[d]    = ($urandom_range(0, 9) != 0);
        in_pc_a[d]    = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 4095)))
                                                    : {$urandom, $urandom};
        in_valid_a[d] = 1'b1;
      end
      out_ready_a[d] = draining ? 1'b1 : ($urandom_range(0, 99) < rp);
      #1;
      occ = exp_q.size();
      check($sformatf("rnd d%0d c%0d out_valid vs occupancy", d, cyc),
            64'(out_valid_a[d]), 64'(occ != 0));
      if (dut_skid(d))
        check($sformatf("rnd d%0d c%0d in_ready skid", d, cyc), 64'(in_ready_a[d]), 64'(occ < 2));
      else
        check($sformatf("rnd d%0d c%0d in_ready single", d, cyc), 64'(in_ready_a[d]),
              64'(occ == 0 || out_ready_a[d]));
      if (out_valid_a[d] && out_ready_a[d] && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_entry(d, $sformatf("rnd c%0d", cyc), e);
      end
      acc_prev = in_valid_a[d] && in_ready_a[d];
      if (acc_prev) exp_q.push_back(model(dut_xlen(d), in_instr_a[d], in_en_a[d], in_pc_a[d]));
    end
    @(negedge clk);
    in_valid_a[d] = 1'b0;
    check($sformatf("rnd d%0d nothing lost", d), 64'(exp_q.size()), 64'd0);
    check($sformatf("rnd d%0d idle at end", d), 64'(out_valid_a[d]), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d]  = 1'b0;
      out_ready_a[d] = 1'b1;
      in_en_a[d]     = 1'b0;
      in_instr_a[d]  = 32'h0;
      in_pc_a[d]     = 64'h0;
    end
    fill_vectors();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset d%0d out_valid", d), 64'(out_valid_a[d]), 64'd0);
      check($sformatf("reset d%0d in_ready", d), 64'(in_ready_a[d]), 64'd1);
      check_entry(d, "reset", pack_exp(64'h0, 3'd0, 1'b0, 1'b0, 64'h0, 64'h0));
    end
    rst_n = 1'b1;
    run_table();
    bp_test();
    reset_stall_test();
    for (int d = 0; d < 3; d++) run_random(d, 300);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
